// File: rtl/oclib_reset_sequencer.sv
// Staged reset sequencer: holds every downstream reset domain for a minimum time,
// then releases them one stage at a time in ascending order.
module oclib_reset_sequencer #(
  parameter int unsigned SyncCycles     = 3,
  parameter int unsigned MinResetCycles = 16,
  parameter int unsigned Stages         = 4,
  parameter int unsigned StageGapCycles = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              resetReq,
  output logic [Stages-1:0] resetOut,
  output logic              resetBusy,
  output logic              resetDone,
  output logic [7:0]        resetCount
);

  localparam int unsigned HoldW = (MinResetCycles > 1) ? $clog2(MinResetCycles) : 1;
  localparam int unsigned GapW  = (StageGapCycles > 1) ? $clog2(StageGapCycles) : 1;
  localparam int unsigned IdxW  = (Stages > 1) ? $clog2(Stages) : 1;

  localparam logic [HoldW-1:0] HoldReload = HoldW'(MinResetCycles - 1);
  localparam logic [GapW-1:0]  GapReload  = GapW'(StageGapCycles - 1);
  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(Stages - 1);
  localparam logic [7:0]       CountMax   = 8'hFF;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StIdle    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SyncCycles-1:0] sync_q, sync_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [Stages-1:0]     out_q, out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            count_q, count_d;
  logic                  req_sync;

  // Plain shift-register synchronizer; the request is treated as fully asynchronous.
  assign sync_d   = {sync_q[SyncCycles-2:0], resetReq};
  assign req_sync = sync_q[SyncCycles-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StHold;
      sync_q  <= '0;
      hold_q  <= HoldReload;
      gap_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; a synced request always wins over a terminal count.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    out_d   = out_q;
    count_d = count_q;

    unique case (state_q)
      StHold: begin
        out_d = '1;
        if (req_sync) begin
          hold_d = HoldReload;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HoldW'(1);
        end else begin
          out_d[0] = 1'b0;
          if (Stages == 1) begin
            state_d = StIdle;
          end else begin
            state_d = StRelease;
            idx_d   = IdxW'(1);
            gap_d   = GapReload;
          end
        end
      end

      StRelease: begin
        if (req_sync) begin
          state_d = StHold;
          out_d   = '1;
          hold_d  = HoldReload;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GapW'(1);
        end else begin
          out_d[idx_q] = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
            gap_d = GapReload;
          end
        end
      end

      StIdle: begin
        out_d = '0;
        if (req_sync) begin
          state_d = StHold;
          out_d   = '1;
          hold_d  = HoldReload;
        end
      end

      default: begin
        state_d = StHold;
        out_d   = '1;
        hold_d  = HoldReload;
      end
    endcase

    // Only completed sequences are counted; aborts re-enter HOLD instead.
    if ((state_d == StIdle) && (state_q != StIdle) && (count_q != CountMax)) begin
      count_d = count_q + 8'd1;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StIdle);
  end

  assign resetOut   = out_q;
  assign resetBusy  = busy_q;
  assign resetDone  = done_q;
  assign resetCount = count_q;

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Directed bench for oclib_reset_sequencer: default build plus a single-stage,
// one-cycle-hold build sharing the same clock and reset.
module tb_oclib_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       req;
  logic       req1;
  logic [3:0] out;
  logic       busy;
  logic       done;
  logic [7:0] cnt;
  logic [0:0] out1;
  logic       busy1;
  logic       done1;
  logic [7:0] cnt1;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;

  oclib_reset_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .resetReq   (req),
    .resetOut   (out),
    .resetBusy  (busy),
    .resetDone  (done),
    .resetCount (cnt)
  );

  oclib_reset_sequencer #(
    .SyncCycles     (3),
    .MinResetCycles (1),
    .Stages         (1),
    .StageGapCycles (8)
  ) dut1 (
    .clock      (clock),
    .reset      (reset),
    .resetReq   (req1),
    .resetOut   (out1),
    .resetBusy  (busy1),
    .resetDone  (done1),
    .resetCount (cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects hold counter freshly loaded and reqSync low: next edge is release-timing edge 1.
  task automatic full_seq(input string tag, input int cnt_exp);
    ticks(15);
    check({tag, "_hold_out"}, 32'(out), 32'hF);
    check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    ticks(1);
    check({tag, "_stage0"}, 32'(out), 32'hE);
    ticks(7);
    check({tag, "_gap0"}, 32'(out), 32'hE);
    ticks(1);
    check({tag, "_stage1"}, 32'(out), 32'hC);
    ticks(8);
    check({tag, "_stage2"}, 32'(out), 32'h8);
    ticks(7);
    check({tag, "_pre_last_out"}, 32'(out), 32'h8);
    check({tag, "_pre_last_busy"}, 32'(busy), 32'd1);
    check({tag, "_pre_last_done"}, 32'(done), 32'd0);
    ticks(1);
    check({tag, "_idle_out"}, 32'(out), 32'h0);
    check({tag, "_idle_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_cnt"}, 32'(cnt), 32'(cnt_exp));
  endtask

  task automatic pulse_req();
    req = 1'b1;
    ticks(1);
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    req1  = 1'b0;

    // 1: power-on reset, then default release timing
    ticks(20);
    check("rst_out", 32'(out), 32'hF);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst1_out", 32'(out1), 32'h1);
    check("rst1_done", 32'(done1), 32'd0);
    reset = 1'b0;
    ticks(1);
    check("s1_edge1_out", 32'(out1), 32'h0);
    check("s1_edge1_done", 32'(done1), 32'd1);
    check("s1_edge1_busy", 32'(busy1), 32'd0);
    check("s1_edge1_cnt", 32'(cnt1), 32'd1);
    check("t1_edge1_out", 32'(out), 32'hF);
    ticks(14);
    check("t1_edge15_out", 32'(out), 32'hF);
    ticks(1);
    check("t1_edge16_out", 32'(out), 32'hE);
    ticks(8);
    check("t1_edge24_out", 32'(out), 32'hC);
    ticks(8);
    check("t1_edge32_out", 32'(out), 32'h8);
    ticks(7);
    check("t1_edge39_busy", 32'(busy), 32'd1);
    ticks(1);
    check("t1_edge40_out", 32'(out), 32'h0);
    check("t1_edge40_done", 32'(done), 32'd1);
    check("t1_edge40_cnt", 32'(cnt), 32'd1);

    // 2: single-cycle request from IDLE
    pulse_req();
    ticks(2);
    check("t2_sync_wait_out", 32'(out), 32'h0);
    ticks(1);
    check("t2_assert_out", 32'(out), 32'hF);
    check("t2_assert_busy", 32'(busy), 32'd1);
    check("t2_assert_done", 32'(done), 32'd0);
    full_seq("t2", 2);

    // 3: abort after stage 1 released
    pulse_req();
    ticks(3);
    check("t3_assert_out", 32'(out), 32'hF);
    ticks(16);
    check("t3_stage0", 32'(out), 32'hE);
    ticks(8);
    check("t3_stage1", 32'(out), 32'hC);
    pulse_req();
    ticks(2);
    check("t3_before_abort", 32'(out), 32'hC);
    ticks(1);
    check("t3_abort_out", 32'(out), 32'hF);
    check("t3_abort_done", 32'(done), 32'd0);
    check("t3_abort_cnt", 32'(cnt), 32'd2);
    full_seq("t3", 3);

    // 4: one-cycle reset mid-RELEASE
    pulse_req();
    ticks(3 + 16 + 8);
    check("t4_stage1", 32'(out), 32'hC);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    check("t4_rst_out", 32'(out), 32'hF);
    check("t4_rst_cnt", 32'(cnt), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd1);
    full_seq("t4", 1);

    // 5: request held high for 100 cycles
    req = 1'b1;
    ticks(3);
    check("t5_sync_wait_out", 32'(out), 32'h0);
    for (int i = 0; i < 97; i++) begin
      ticks(1);
      check("t5_held_out", 32'(out), 32'hF);
    end
    req = 1'b0;
    ticks(3);
    check("t5_drop_out", 32'(out), 32'hF);
    full_seq("t5", 2);

    // 6: back-to-back sequences drive the counter into saturation
    exp_cnt = 2;
    for (int i = 0; i < 300; i++) begin
      pulse_req();
      ticks(43);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check("t6_done", 32'(done), 32'd1);
      check("t6_cnt", 32'(cnt), 32'(exp_cnt));
    end
    check("t6_cnt_sat", 32'(cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oclib_reset_sequencer.md
Name: oclib_reset_sequencer

Overview:
- Consumes the raw simulation/board reset and an asynchronous soft-reset request.
- Holds all downstream reset domains asserted for a guaranteed minimum time.
- Then releases them one stage at a time, stage 0 first, with a fixed gap between stages.
- Sits directly downstream of the top-level reset generator and drives the per-subsystem resets of the chip/testbench.

Parameters:
SyncCycles, 3, depth of the synchronizer on resetReq (legal: >=2)
MinResetCycles, 16, cycles all stages stay asserted after reset and the synced request are both low (legal: >=1)
Stages, 4, number of staged reset outputs (legal: 1..16)
StageGapCycles, 8, cycles between successive stage releases (legal: >=1)

Ports:
clock  input  1  single clock for all logic
reset  input  1  synchronous, active-high reset; from upstream reset generator
resetReq  input  1  asynchronous soft-reset request, active-high, any pulse width >= 1 clock
resetOut  output  Stages  per-stage reset, active-high; bit i released before bit i+1
resetBusy  output  1  high whenever any resetOut bit is asserted
resetDone  output  1  high when all stages released (state IDLE)
resetCount  output  8  completed sequences since reset, saturates at 255

Behaviour:
- Reset values (at any edge with reset=1): resetOut=all ones, resetBusy=1, resetDone=0, resetCount=0, sync chain=0, state=HOLD, hold counter=MinResetCycles-1.
- Synchronizer: resetReq passes through SyncCycles flops; reqSync = last flop. Latency from resetReq to reqSync is SyncCycles edges.
- HOLD:
  - resetOut all ones.
  - If reqSync=1, reload the hold counter to MinResetCycles-1.
  - Else if counter!=0, decrement.
  - Else (counter==0, reqSync=0): clear resetOut[0] at this edge.
    - Stages==1: go to IDLE.
    - Otherwise: go to RELEASE with idx=1 and gap counter=StageGapCycles-1.
- RELEASE:
  - If reqSync=1: go to HOLD, set resetOut=all ones, reload the hold counter (abort).
  - Else if gap counter!=0, decrement.
  - Else clear resetOut[idx].
    - idx==Stages-1: go to IDLE.
    - Otherwise: idx++ and reload the gap counter.
- IDLE:
  - resetOut=0.
  - reqSync=1: go to HOLD, set resetOut=all ones, reload the hold counter.
- resetCount increments by 1 on each transition into IDLE, saturating at 255. Aborted sequences do not count.
- resetBusy = (state!=IDLE); resetDone = (state==IDLE). Both are registered, consistent with resetOut in the same cycle.
- Timing: with reset low from edge 1 and no request:
  - resetOut[0] falls at edge MinResetCycles.
  - resetOut[i] falls at edge MinResetCycles + i*StageGapCycles.
- Simultaneous events:
  - reset beats everything.
  - reqSync=1 beats the hold/gap terminal count (no stage is released in that cycle).
- Reset mid-sequence: next edge returns to reset values, including resetCount=0.
- A request held high keeps all stages asserted indefinitely. Release timing restarts from the cycle reqSync falls.
- Outputs only transition 0->1 as a whole vector, never partially. Release order is strictly ascending.

Test Plan:
1. Defaults; reset high 20 cycles, then low (edge 1 = first low sample):
   - resetOut[0] falls at edge 16, [1] at 24, [2] at 32, [3] at 40.
   - resetDone=1 and resetCount=1 after edge 40.
   - resetBusy=1 before edge 40.
2. In IDLE, 1-cycle resetReq pulse sampled at edge E:
   - resetOut=4'hF after edge E+3 (synced), with resetBusy=1.
   - resetOut[0] falls 16 edges after reqSync drops, then the stepped release as in 1.
   - resetCount=2.
3. Request pulse after resetOut[1] released (mid-RELEASE):
   - All four stages reasserted on the edge after reqSync=1.
   - Full sequence repeats; resetCount increments by exactly 1 total.
4. reset asserted for 1 cycle mid-RELEASE:
   - resetOut=4'hF, resetCount=0, resetDone=0 after that edge.
   - Sequence restarts with timing as in 1.
5. resetReq held high 100 cycles:
   - resetOut stays 4'hF throughout, with no partial release.
   - resetOut[0] falls 16 edges after reqSync falls.
6. 300 back-to-back complete sequences via request pulses: resetCount reaches 255 and stays 255. Also build with Stages=1, MinResetCycles=1: resetOut[0] falls at edge 1 after reset and resetDone=1 the same cycle.
